main_memory_ctrl: RTL

Two-port controller that sequences and shares the single main-memory datapath between the data cache (port 0, miss refill / write-back) and the page-table walker (port 1, PTE fetch). It sits between those requesters and `main_memory`. It arbitrates round-robin, drives the memory's `write`/`address`/`write_data` for a fixed access occupancy, and returns one 64-bit block per request with a single-cycle response pulse.

---
 rtl/main_memory_ctrl_pkg.sv | 18 +
 rtl/main_memory_ctrl_if.sv | 57 +++++
 rtl/main_memory_ctrl_rr_arbiter2.sv | 44 ++++
 rtl/main_memory_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared definitions for the main-memory controller.
//   state_e        : controller FSM encoding (2 bits).
//   DefaultLatency : default memory occupancy per access, in cycles.
//   BlockOffW      : byte-offset width inside one 64-bit block.
//   CntW           : occupancy counter width (covers LATENCY 1..15).
package main_memory_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam int unsigned DefaultLatency = 4;
  localparam int unsigned BlockOffW      = 3;
  localparam int unsigned CntW           = 4;

endpackage

// File: rtl/main_memory_ctrl_if.sv
// Bus bundle between the two requesters (port 0 = data cache, port 1 = page-table walker),
// the controller, and main memory.
//   req*_valid/write/addr/wdata : request side, held until req*_ready.
//   req*_ready                  : accept strobe from the controller.
//   resp*_valid/rdata           : one-cycle completion pulse and read block.
//   mem_write/addr/wdata        : drive main memory; mem_rdata returns its read data.
//   busy                        : controller is not idle.
// Modports: slave = controller, master = requesters plus memory (the environment).
interface main_memory_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
) ();

  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_rdata;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, resp0_valid, resp0_rdata,
    output req1_ready, resp1_valid, resp1_rdata,
    output mem_write, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, resp0_valid, resp0_rdata,
    input  req1_ready, resp1_valid, resp1_rdata,
    input  mem_write, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/main_memory_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter (rr_arbiter2) for the main-memory controller.
//   clk, reset : clock and synchronous active-high reset (pointer returns to port 0).
//   req        : request valids, bit N = port N.
//   advance    : pulsed while a response is issued; moves the pointer.
//   served     : port whose response is being issued while advance is high.
//   grant      : one-hot grant; a lone requester always wins, a tie goes to the pointer.
module main_memory_ctrl_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Priority passes to the port that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ~served;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory controller: shares one main-memory datapath between the data cache (port 0)
// and the page-table walker (port 1). One access is outstanding at a time: a request is
// accepted in IDLE, the memory is held for LATENCY cycles in ACCESS, and a one-cycle
// response is issued in RESP.
//   clk, reset : clock and synchronous active-high reset; reset forces every output to 0.
//   bus        : slave side of main_memory_ctrl_if (requests, responses, memory drive, busy).
// Parameters: ADDR_W byte-address width, DATA_W block width, LATENCY occupancy (1..15).
module main_memory_ctrl
  import main_memory_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LATENCY = DefaultLatency
) (
  input logic               clk,
  input logic               reset,
  main_memory_ctrl_if.slave bus
);

  localparam logic [CntW-1:0]   CntLoad  = CntW'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'((1 << BlockOffW) - 1);

  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  main_memory_ctrl_rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (state_q == StResp),
    .served  (id_q),
    .grant   (grant)
  );

  // Grant depends only on valids and the pointer, so ready has no path from mem_rdata.
  assign accept = (state_q == StIdle) && (grant != 2'b00);
  assign sel    = grant[1];

  always_comb begin
    req_write = sel ? bus.req1_write : bus.req0_write;
    req_addr  = sel ? bus.req1_addr  : bus.req0_addr;
    req_wdata = sel ? bus.req1_wdata : bus.req0_wdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StAccess;
      StAccess: if (cnt_q == '0) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Latched request, occupancy counter and response block.
  always_comb begin
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = CntLoad;
          wr_d    = req_write;
          addr_d  = req_addr & AddrMask;
          wdata_d = req_wdata;
          id_d    = sel;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Read data is sampled in the last cycle the address is held.
          rdata_d = wr_q ? '0 : bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        rdata_d = '0;
      end
      default: begin
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs. Reset is synchronous, so the state may still be ACCESS/RESP in the reset
  // cycle; gating on reset keeps every output at 0 while it is asserted.
  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    bus.resp0_rdata = '0;
    bus.resp1_rdata = '0;
    bus.mem_write   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.busy        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          bus.req0_ready = grant[0];
          bus.req1_ready = grant[1];
        end
        StAccess: begin
          bus.busy      = 1'b1;
          bus.mem_write = wr_q;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = wdata_q;
        end
        StResp: begin
          bus.busy = 1'b1;
          if (id_q) begin
            bus.resp1_valid = 1'b1;
            bus.resp1_rdata = rdata_q;
          end else begin
            bus.resp0_valid = 1'b1;
            bus.resp0_rdata = rdata_q;
          end
        end
        default: begin
          bus.busy = 1'b0;
        end
      endcase
    end
  end

endmodule
